// File: rtl/scenario_pkg.sv
// Shared types for the firing-sequence core: FSM state codes (also the
// externally visible state byte) and the scenario selector.
package scenario_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [7:0] {
        ST_IDLE        = 8'h00,
        ST_WAIT_FG     = 8'h02,
        ST_FG_DELAY    = 8'h03,
        ST_WAIT_DET    = 8'h04,
        ST_WAIT_PHASE  = 8'h05,
        ST_PHASE_DELAY = 8'h06,
        ST_DETONATE    = 8'h07,
        ST_WAIT_WIRE   = 8'h08,
        ST_TRIGGER     = 8'h09,
        ST_DONE        = 8'h0A,
        ST_TIMEOUT     = 8'hFF
    } state_e;

    typedef enum logic [2:0] {
        SCN_OFF       = 3'd0,
        SCN_DIRECT    = 3'd1,
        SCN_FAST_GATE = 3'd2,
        SCN_PHASE     = 3'd3
    } scenario_e;

    // Codes 4..7 are reserved and behave as "off".
    function automatic scenario_e decode_scn(input logic [2:0] ctl);
        return (ctl > 3'd3) ? SCN_OFF : scenario_e'(ctl);
    endfunction

endpackage

// File: rtl/input_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with a rising-edge strobe
// derived from the synchronized level.
module input_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/scenario_mux.sv
// Firing-sequence core: picks a scenario, walks start / fast-gate / detector /
// phase conditions, then emits a timed detonation and a wire-triggered pulse.
module scenario_mux
    import scenario_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock_reg_input,
    input  logic             reset_reg_input,
    input  logic [2:0]       control_reg_input,
    input  logic             start_reg_input,
    input  logic             fg_reg_input,
    input  logic             phase_reg_input,
    input  logic             wire_reg_input,
    input  logic             detector_ready_reg_input,
    input  logic [CNT_W-1:0] fg_open_delay_reg_input,
    input  logic [CNT_W-1:0] detectr_ready_timeout_reg_input,
    input  logic [CNT_W-1:0] phase_shift_reg_input,
    input  logic [CNT_W-1:0] detonate_len_reg_input,
    input  logic [CNT_W-1:0] trigger_len_reg_input,
    output logic             detonation_signal_reg_output,
    output logic             trigger_reg_output,
    output logic [7:0]       scenario_state_reg_output,
    output logic [CNT_W-1:0] counter_reg_output,
    output logic [2:0]       scenario_reg_output
);

    localparam int N_IN = 5;

    logic [N_IN-1:0] w_async, w_lvl, w_rise;
    logic            w_unused;
    scenario_e       w_scn_ctl;

    state_e          r_state;
    scenario_e       r_scn;
    logic [CNT_W-1:0] r_cnt;
    logic            r_det, r_trig;

    // Bit order: start, fg, phase, wire, detector_ready.
    assign w_async = {detector_ready_reg_input, wire_reg_input, phase_reg_input,
                      fg_reg_input, start_reg_input};

    for (genvar g = 0; g < N_IN; g++) begin : g_sync
        input_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .i_clk   (clock_reg_input),
            .i_rst_n (reset_reg_input),
            .i_async (w_async[g]),
            .o_level (w_lvl[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_unused  = &{1'b0, w_rise[4], w_lvl[3:1]};
    assign w_scn_ctl = decode_scn(control_reg_input);

    // True on the final cycle of a timed state; a length of 0 still lasts one cycle.
    function automatic logic last_cycle(input logic [CNT_W-1:0] cnt,
                                        input logic [CNT_W-1:0] len);
        return (len <= CNT_W'(1)) || (cnt >= len - CNT_W'(1));
    endfunction

    always_ff @(posedge clock_reg_input) begin
        if (!reset_reg_input) begin
            r_state <= ST_IDLE;
            r_scn   <= SCN_OFF;
            r_cnt   <= '0;
            r_det   <= 1'b0;
            r_trig  <= 1'b0;
        end else begin
            r_cnt <= (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_scn <= w_scn_ctl;
                    if (w_rise[0] && (w_scn_ctl == SCN_DIRECT)) begin
                        r_state <= ST_DETONATE;
                        r_det   <= 1'b1;
                    end else if (w_rise[0] && (w_scn_ctl != SCN_OFF)) begin
                        r_state <= ST_WAIT_FG;
                    end
                end
                ST_WAIT_FG: if (w_rise[1]) begin
                    r_state <= ST_FG_DELAY;
                    r_cnt   <= '0;
                end
                ST_FG_DELAY: if (last_cycle(r_cnt, fg_open_delay_reg_input)) begin
                    r_state <= ST_WAIT_DET;
                    r_cnt   <= '0;
                end
                ST_WAIT_DET: begin
                    // Ready is checked first so it wins over a coincident timeout.
                    if (w_lvl[4]) begin
                        r_cnt <= '0;
                        if (r_scn == SCN_PHASE) begin
                            r_state <= ST_WAIT_PHASE;
                        end else begin
                            r_state <= ST_DETONATE;
                            r_det   <= 1'b1;
                        end
                    end else if ((detectr_ready_timeout_reg_input != '0) &&
                                 (r_cnt >= detectr_ready_timeout_reg_input - CNT_W'(1))) begin
                        r_state <= ST_TIMEOUT;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT_PHASE: if (w_rise[2]) begin
                    r_state <= ST_PHASE_DELAY;
                    r_cnt   <= '0;
                end
                ST_PHASE_DELAY: if (last_cycle(r_cnt, phase_shift_reg_input)) begin
                    r_state <= ST_DETONATE;
                    r_cnt   <= '0;
                    r_det   <= 1'b1;
                end
                ST_DETONATE: if (last_cycle(r_cnt, detonate_len_reg_input)) begin
                    r_state <= ST_WAIT_WIRE;
                    r_cnt   <= '0;
                    r_det   <= 1'b0;
                end
                ST_WAIT_WIRE: if (w_rise[3]) begin
                    r_state <= ST_TRIGGER;
                    r_cnt   <= '0;
                    r_trig  <= 1'b1;
                end
                ST_TRIGGER: if (last_cycle(r_cnt, trigger_len_reg_input)) begin
                    r_state <= ST_DONE;
                    r_cnt   <= '0;
                    r_trig  <= 1'b0;
                end
                ST_DONE, ST_TIMEOUT: begin
                    r_cnt <= '0;
                    if (!w_lvl[0]) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_det   <= 1'b0;
                    r_trig  <= 1'b0;
                end
            endcase
        end
    end

    assign detonation_signal_reg_output = r_det;
    assign trigger_reg_output           = r_trig;
    assign scenario_state_reg_output    = r_state;
    assign counter_reg_output           = r_cnt;
    assign scenario_reg_output          = r_scn;

endmodule

// File: tb/tb_scenario_mux.sv
// Directed + randomized bench: expected state sequence and dwell times are
// derived arithmetically from the scenario rules and compared with a trace.
module tb_scenario_mux;

    localparam int W = 32;
    localparam int LAT = 3;  // pin-to-transition latency with 2 sync stages

    logic         clk = 1'b0, rst_n = 1'b0;
    logic [2:0]   ctl = 3'd0;
    logic         start = 1'b0, fg = 1'b0, ph = 1'b0, wr = 1'b0, rdy = 1'b0;
    logic [W-1:0] fgd = '0, tmo = '0, pshift = '0, dlen = '0, tlen = '0;
    logic         det_o, trig_o;
    logic [7:0]   st_o;
    logic [W-1:0] cnt_o;
    logic [2:0]   scn_o;

    int n_assert = 0, n_fail = 0;

    logic [7:0] st_q[$], e_st[$];
    int         dw_q[$], e_dw[$];
    logic [7:0] cur_st;
    int         cur_dw, det_cyc, trig_cyc, overlap, cnt_bad, pulse_bad;

    scenario_mux #(.CNT_W(W), .SYNC_STAGES(2)) dut (
        .clock_reg_input                 (clk),
        .reset_reg_input                 (rst_n),
        .control_reg_input               (ctl),
        .start_reg_input                 (start),
        .fg_reg_input                    (fg),
        .phase_reg_input                 (ph),
        .wire_reg_input                  (wr),
        .detector_ready_reg_input        (rdy),
        .fg_open_delay_reg_input         (fgd),
        .detectr_ready_timeout_reg_input (tmo),
        .phase_shift_reg_input           (pshift),
        .detonate_len_reg_input          (dlen),
        .trigger_len_reg_input           (tlen),
        .detonation_signal_reg_output    (det_o),
        .trigger_reg_output              (trig_o),
        .scenario_state_reg_output       (st_o),
        .counter_reg_output              (cnt_o),
        .scenario_reg_output             (scn_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One cycle: sample at negedge, extend the state trace, tally pulse/counter rules.
    task automatic tick();
        int e;
        @(negedge clk);
        if (st_o !== cur_st) begin
            st_q.push_back(cur_st);
            dw_q.push_back(cur_dw);
            cur_st = st_o;
            cur_dw = 1;
        end else cur_dw++;
        if (det_o) det_cyc++;
        if (trig_o) trig_cyc++;
        if (det_o && trig_o) overlap++;
        if (det_o !== (st_o == 8'h07)) pulse_bad++;
        if (trig_o !== (st_o == 8'h09)) pulse_bad++;
        e = (st_o == 8'h00 || st_o == 8'h0A || st_o == 8'hFF) ? 0 : cur_dw - 1;
        if (cnt_o !== W'(e)) cnt_bad++;
    endtask

    task automatic clear_trace();
        st_q.delete(); dw_q.delete(); e_st.delete(); e_dw.delete();
        cur_st = st_o; cur_dw = 0;
        det_cyc = 0; trig_cyc = 0; overlap = 0; cnt_bad = 0; pulse_bad = 0;
    endtask

    task automatic expect_seg(input logic [7:0] s, input int d);
        e_st.push_back(s);
        e_dw.push_back(d);
    endtask

    task automatic wait_st(input logic [7:0] target);
        int n = 0;
        do begin tick(); n++; end while (st_o !== target && n < 400);
        if (st_o !== target) check("wait_state_bound", st_o, target);
    endtask

    task automatic set_pin(input int which, input logic v);
        case (which)
            0: fg = v;
            1: ph = v;
            default: wr = v;
        endcase
    endtask

    // Raise a pin after w cycles and hold it for two cycles.
    task automatic pulse(input int which, input int w);
        repeat (w) tick();
        set_pin(which, 1'b1);
        tick(); tick();
        set_pin(which, 1'b0);
    endtask

    function automatic int mx1(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    task automatic compare_trace(input string nm);
        int n;
        check({nm, "_segments"}, st_q.size(), e_st.size());
        n = (st_q.size() < e_st.size()) ? st_q.size() : e_st.size();
        for (int i = 1; i < n; i++) begin
            check($sformatf("%s_seg%0d_state", nm, i), st_q[i], e_st[i]);
            if (e_dw[i] >= 0) check($sformatf("%s_seg%0d_dwell", nm, i), dw_q[i], e_dw[i]);
        end
        check({nm, "_counter"}, cnt_bad, 0);
        check({nm, "_pulse_vs_state"}, pulse_bad, 0);
        check({nm, "_overlap"}, overlap, 0);
    endtask

    task automatic run(input string nm, input int scn, input int dl, input int tl,
                       input int fgdv, input int ps, input int tmov, input bit rdyv,
                       input int wf, input int wp, input int ww, input bit pre,
                       input bit wire_ign);
        ctl = 3'(scn); dlen = W'(dl); tlen = W'(tl); fgd = W'(fgdv);
        pshift = W'(ps); tmo = W'(tmov); rdy = rdyv;
        repeat (4) tick();
        clear_trace();
        expect_seg(8'h00, -1);
        start = 1'b1;
        if (scn == 1) begin
            expect_seg(8'h07, mx1(dl));
        end else begin
            wait_st(8'h02);
            if (pre) pulse(1, 0);
            pulse(0, wf);
            expect_seg(8'h02, wf + LAT + (pre ? 2 : 0));
            expect_seg(8'h03, mx1(fgdv));
            if (!rdyv) begin
                expect_seg(8'h04, tmov);
                expect_seg(8'hFF, -1);
                wait_st(8'hFF);
                ctl = 3'($urandom_range(0, 7));
                repeat (4) tick();
                check({nm, "_timeout_hold"}, st_o, 8'hFF);
                check({nm, "_scn_latched"}, scn_o, scn);
                check({nm, "_no_detonation"}, det_cyc, 0);
                check({nm, "_no_trigger"}, trig_cyc, 0);
                start = 1'b0;
                wait_st(8'h00);
                compare_trace(nm);
                return;
            end
            expect_seg(8'h04, 1);
            if (scn == 3) begin
                wait_st(8'h05);
                pulse(1, wp);
                expect_seg(8'h05, wp + LAT);
                expect_seg(8'h06, mx1(ps));
            end
            expect_seg(8'h07, mx1(dl));
        end
        if (wire_ign) begin
            wait_st(8'h07);
            pulse(2, 0);
        end
        wait_st(8'h08);
        ctl = 3'($urandom_range(0, 7));
        pulse(2, ww);
        expect_seg(8'h08, ww + LAT);
        expect_seg(8'h09, mx1(tl));
        expect_seg(8'h0A, -1);
        wait_st(8'h0A);
        repeat (4) tick();
        check({nm, "_done_hold"}, st_o, 8'h0A);
        check({nm, "_scn_latched"}, scn_o, scn);
        check({nm, "_det_cycles"}, det_cyc, mx1(dl));
        check({nm, "_trig_cycles"}, trig_cyc, mx1(tl));
        start = 1'b0;
        wait_st(8'h00);
        compare_trace(nm);
    endtask

    initial begin
        int s, r;
        cur_st = 8'h00;
        clear_trace();
        repeat (3) tick();
        check("reset_state", st_o, 8'h00);
        check("reset_det", det_o, 1'b0);
        check("reset_trig", trig_o, 1'b0);
        check("reset_cnt", cnt_o, 0);
        check("reset_scn", scn_o, 0);
        rst_n = 1'b1;
        tick();

        run("direct",     1, 5, 3, 0, 0, 0, 1, 0, 0, 17, 0, 1);
        run("fastgate",   2, 2, 2, 10, 0, 0, 1, 3, 0, 2, 0, 0);
        run("timeout",    2, 1, 1, 4, 0, 50, 0, 1, 0, 0, 0, 0);
        run("phase",      3, 4, 1, 2, 7, 0, 1, 2, 5, 2, 1, 1);
        run("zero_len",   1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        run("rdy_vs_tmo", 2, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0);
        run("tmo_one",    3, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 8; k++) begin
            s = $urandom_range(1, 3);
            r = $urandom_range(0, 3);
            run($sformatf("rand%0d", k), s, $urandom_range(0, 8), $urandom_range(0, 5),
                $urandom_range(0, 12), $urandom_range(0, 9),
                (r == 0) ? $urandom_range(1, 30) : $urandom_range(0, 30), r != 0,
                $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                $urandom_range(0, 1), 1'b0);
        end

        // Off and reserved scenario codes never leave IDLE.
        for (int v = 3; v < 8; v++) begin
            ctl = (v == 3) ? 3'd0 : 3'(v);
            clear_trace();
            start = 1'b1;
            repeat (8) tick();
            check($sformatf("off%0d_state", ctl), st_o, 8'h00);
            check($sformatf("off%0d_scn", ctl), scn_o, 0);
            check($sformatf("off%0d_pulses", ctl), det_cyc + trig_cyc, 0);
            start = 1'b0;
            repeat (4) tick();
        end
        ctl = 3'd2;
        repeat (2) tick();
        check("idle_scn_follows", scn_o, 2);

        // Reset during detonation drops everything on the next edge.
        ctl = 3'd1; dlen = W'(10);
        start = 1'b1;
        wait_st(8'h07);
        tick();
        check("pre_reset_det", det_o, 1'b1);
        rst_n = 1'b0;
        tick();
        check("rst_det", det_o, 1'b0);
        check("rst_trig", trig_o, 1'b0);
        check("rst_state", st_o, 8'h00);
        check("rst_cnt", cnt_o, 0);
        check("rst_scn", scn_o, 0);
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
